// File: rtl/fp_mult_norm_round.sv
// -----------------------------------------------------------------------------
// fp_mult_norm_round
//
// This is the back-end stage of the single-precision FP multiplier. It receives
// the raw product of the front end:
//   - the sign
//   - the rebiased exponent sum
//   - the full 48-bit significand product, with the hidden bits included
//
// The stage then:
//   1. Normalises the significand so the leading one sits at bit 46, shifting
//      one bit per cycle.
//   2. Rounds to nearest-even.
//   3. Packs an IEEE-754 binary32 word with overflow, underflow and inexact
//      flags.
//
// Only one operation is in flight at a time. A new operand is accepted only
// after the previous result has been taken.
//
// Handshake: a transfer happens on any rising clk edge where valid and ready
// are both high. A producer holds valid, and its payload stable, until that
// edge. On the input side, in_ready is high only in IDLE. On the output side,
// out_valid and the result fields are held until out_ready is seen.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      upstream product valid
//   in_ready     out  1      stage can accept (IDLE only)
//   in_sign      in   1      sign_a ^ sign_b
//   in_exp       in   EXP_W  signed exp_a + exp_b - 127
//   in_mant      in   48     {1,frac_a}*{1,frac_b}, binary point between 46/45
//   in_zero      in   1      either operand is zero
//   out_valid    out  1      result valid, held until accepted
//   out_ready    in   1      downstream accepts
//   out_data     out  32     {sign, exp[7:0], frac[22:0]}
//   out_ovf      out  1      result saturated to infinity
//   out_unf      out  1      result flushed to zero
//   out_inexact  out  1      rounding lost bits, or result overflowed/flushed
//   dbg_state_o  out  2      current FSM state, for observation only
// -----------------------------------------------------------------------------
module fp_mult_norm_round #(
  parameter int EXP_W      = 10,
  parameter int MAX_LSHIFT = 47
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [47:0]             in_mant,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_inexact,
  output logic [1:0]              dbg_state_o
);

  localparam int SHIFT_W = $clog2(MAX_LSHIFT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [SHIFT_W-1:0]      SHIFT_LIM = SHIFT_W'(MAX_LSHIFT);

  logic [1:0]              state_q,     state_d;
  logic                    sign_q,      sign_d;
  logic signed [EXP_W-1:0] exp_q,       exp_d;
  logic [47:0]             mant_q,      mant_d;
  logic                    zero_q,      zero_d;
  logic [SHIFT_W-1:0]      shift_q,     shift_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             out_data_q,  out_data_d;
  logic                    ovf_q,       ovf_d;
  logic                    unf_q,       unf_d;
  logic                    inexact_q,   inexact_d;

  // Rounding datapath. It is combinational from the normalised mantissa and
  // is only consumed in ROUND.
  logic                    rnd_lsb;
  logic                    rnd_guard;
  logic                    rnd_sticky;
  logic                    rnd_up;
  logic [24:0]             rnd_sum;
  logic                    rnd_carry;
  logic [23:0]             sig24;
  logic signed [EXP_W-1:0] exp_rnd;

  always_comb begin
    rnd_lsb    = mant_q[23];
    rnd_guard  = mant_q[22];
    rnd_sticky = |mant_q[21:0];
    // Ties go to even: on an exact half, round up only when the LSB is odd.
    rnd_up     = rnd_guard & (rnd_sticky | rnd_lsb);
    rnd_sum    = {1'b0, mant_q[46:23]} + {24'd0, rnd_up};
    rnd_carry  = rnd_sum[24];
    // A carry out of 1.111..1 gives 10.000..0. Renormalise to 1.0 and bump
    // the exponent.
    sig24      = rnd_carry ? 24'h800000 : rnd_sum[23:0];
    exp_rnd    = exp_q + EXP_W'(rnd_carry);
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    zero_d      = zero_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inexact_d   = inexact_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          zero_d  = in_zero;
          shift_d = '0;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (zero_q || (mant_q == '0)) begin
          zero_d  = 1'b1;
          state_d = ST_ROUND;
        end else if (mant_q[47]) begin
          // Product lies in [2,4). The bit that drops off the bottom must
          // still count toward sticky, so fold it into bit 0.
          mant_d  = {1'b0, mant_q[47:1]} | {47'd0, mant_q[0]};
          exp_d   = exp_q + EXP_W'(1);
          state_d = ST_ROUND;
        end else if (mant_q[46]) begin
          state_d = ST_ROUND;
        end else if (shift_q == SHIFT_LIM) begin
          // Runaway guard: a nonzero mantissa always normalises well before
          // this limit is reached.
          zero_d  = 1'b1;
          state_d = ST_ROUND;
        end else begin
          mant_d  = {mant_q[46:0], 1'b0};
          exp_d   = exp_q - EXP_W'(1);
          shift_d = shift_q + SHIFT_W'(1);
        end
      end

      ST_ROUND: begin
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        inexact_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
        if (zero_q) begin
          out_data_d = {sign_q, 31'd0};
        end else if (exp_rnd >= EXP_INF) begin
          out_data_d = {sign_q, 8'hFF, 23'd0};
          ovf_d      = 1'b1;
          inexact_d  = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
          // Subnormals are not produced; anything below the normal range
          // flushes to signed zero.
          out_data_d = {sign_q, 31'd0};
          unf_d      = 1'b1;
          inexact_d  = 1'b1;
        end else begin
          out_data_d = {sign_q, exp_rnd[7:0], sig24[22:0]};
          inexact_d  = rnd_guard | rnd_sticky;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      zero_q      <= 1'b0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      zero_q      <= zero_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inexact_q   <= inexact_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = ovf_q;
  assign out_unf     = unf_q;
  assign out_inexact = inexact_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// -----------------------------------------------------------------------------
// Testbench for fp_mult_norm_round.
// Directed vectors with hand-computed results. Each expected result is packed
// as {ovf, unf, inexact, data[31:0]}.
// -----------------------------------------------------------------------------
module tb_fp_mult_norm_round;

  localparam int EXP_W = 10;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [47:0]      in_mant;
  logic             in_zero;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_ovf;
  logic             out_unf;
  logic             out_inexact;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [34:0] exp_q[$];

  fp_mult_norm_round #(
    .EXP_W(EXP_W),
    .MAX_LSHIFT(47)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sign(in_sign),
    .in_exp(in_exp),
    .in_mant(in_mant),
    .in_zero(in_zero),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf),
    .out_unf(out_unf),
    .out_inexact(out_inexact),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one operand and waits for its result. If hold is nonzero, the
  // result is back-pressured for that many cycles and must stay put.
  task automatic run_vec(input string tag, input logic sign, input logic [EXP_W-1:0] exp_in,
                         input logic [47:0] mant, input logic zero, input logic [34:0] exp_word,
                         input int exp_lat, input int hold);
    int lat;
    logic [34:0] got;
    logic [34:0] e;
    exp_q.push_back(exp_word);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check_eq({tag, ".rdy_pre"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_sign   = sign;
    in_exp    = exp_in;
    in_mant   = mant;
    in_zero   = zero;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = '0;
    in_mant  = '0;
    in_zero  = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, ".rdy_busy"}, 64'(in_ready), 64'd0);
    got = {out_ovf, out_unf, out_inexact, out_data};
    e = exp_q.pop_front();
    check_eq({tag, ".data"}, 64'(got[31:0]), 64'(e[31:0]));
    check_eq({tag, ".flags"}, 64'(got[34:32]), 64'(e[34:32]));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_eq({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".hold_result"}, 64'({out_ovf, out_unf, out_inexact, out_data}), 64'(got));
        check_eq({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".valid_post"}, 64'(out_valid), 64'd0);
    check_eq({tag, ".rdy_post"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.rdy", 64'(in_ready), 64'd1);
    check_eq("reset.valid", 64'(out_valid), 64'd0);
    check_eq("reset.result", 64'({out_ovf, out_unf, out_inexact, out_data}), 64'd0);
    check_eq("reset.state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 * 1.0
    run_vec("one", 1'b0, 10'd127, 48'h400000000000, 1'b0, {3'b000, 32'h3F800000}, 2, 0);
    // 1.5 * 1.5 = 2.25, one right shift
    run_vec("p225", 1'b0, 10'd127, 48'h900000000000, 1'b0, {3'b000, 32'h40100000}, 2, 0);
    // Round-nearest-even ties
    run_vec("tie_odd", 1'b0, 10'd127, 48'h400000C00000, 1'b0, {3'b001, 32'h3F800002}, 2, 0);
    run_vec("tie_even", 1'b0, 10'd127, 48'h400000400000, 1'b0, {3'b001, 32'h3F800000}, 2, 0);
    // Rounding carry out renormalises to 2.0
    run_vec("rnd_carry", 1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, {3'b001, 32'h40000000}, 2, 0);
    // Right shift: the bit dropped off the bottom must break the tie upward
    run_vec("rsh_sticky", 1'b0, 10'd127, 48'h800000800001, 1'b0, {3'b001, 32'h40000001}, 2, 0);
    // Overflow after the right shift bumps exp to 255
    run_vec("ovf", 1'b0, 10'd254, 48'h800000000000, 1'b0, {3'b101, 32'h7F800000}, 2, 0);
    // Overflow caused only by the rounding carry
    run_vec("ovf_carry", 1'b1, 10'd254, 48'h7FFFFFC00000, 1'b0, {3'b101, 32'hFF800000}, 2, 0);
    // Underflow at exp 0, negative sign
    run_vec("unf", 1'b1, 10'd0, 48'h400000000000, 1'b0, {3'b011, 32'h80000000}, 2, 0);
    // Smallest normal
    run_vec("min_norm", 1'b0, 10'd1, 48'h400000000000, 1'b0, {3'b000, 32'h00800000}, 2, 0);
    // Zero operand, with and without sign, and mant==0 without the flag
    run_vec("zero", 1'b0, 10'd127, 48'h400000000000, 1'b1, {3'b000, 32'h00000000}, 2, 0);
    run_vec("zero_neg", 1'b1, 10'd200, 48'h123456789ABC, 1'b1, {3'b000, 32'h80000000}, 2, 0);
    run_vec("mant0", 1'b1, 10'd127, 48'h000000000000, 1'b0, {3'b000, 32'h80000000}, 2, 0);
    // Two left shifts
    run_vec("lsh2", 1'b0, 10'd130, 48'h100000000000, 1'b0, {3'b000, 32'h40000000}, 4, 0);
    // Left shifts into underflow (exp 2 -> 0)
    run_vec("lsh_unf", 1'b0, 10'd2, 48'h100000000000, 1'b0, {3'b011, 32'h00000000}, 4, 0);
    // Backpressure on a negative result
    run_vec("bp", 1'b1, 10'd128, 48'h600000000000, 1'b0, {3'b000, 32'hC0400000}, 2, 5);

    // Reset while in NORM
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 10'd130;
    in_mant  = 48'h100000000000;
    in_zero  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("rstnorm.state", 64'(dbg_state), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rstnorm.state0", 64'(dbg_state), 64'd0);
    check_eq("rstnorm.rdy", 64'(in_ready), 64'd1);
    check_eq("rstnorm.valid", 64'(out_valid), 64'd0);
    check_eq("rstnorm.result", 64'({out_ovf, out_unf, out_inexact, out_data}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", 1'b1, 10'd127, 48'h400000000000, 1'b0, {3'b000, 32'hBF800000}, 2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
